// File: rtl/ddr2_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_port_arbiter
//   Shares the single-word ddr2_sys port between the frame write path
//   (camera side, draining the write FIFO) and the frame read path (filling
//   the display read FIFO). One transaction at a time: IDLE -> WR|RD -> DONE
//   -> IDLE, with the waitrequest handshake run in WR/RD. Consecutive grants
//   per client are capped while the other client waits, so neither starves.
//
// Ports (all in the ctrl_clk domain, rising edge):
//   ctrl_clk, reset            clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data     write client request, held until wr_ack
//   wr_ack                     1-cycle pulse, write committed
//   rd_req/rd_addr             read client request, held until rd_ack
//   rd_ack/rd_data             1-cycle pulse; rd_data holds the last read word
//   mem_write/mem_read         commands to ddr2_sys (never both high)
//   mem_addr/mem_wdata         word-aligned address and write data
//   mem_rdata/mem_waitrequest  from ddr2_sys; command accepted when wait low
//   busy                       high whenever not IDLE
// ---------------------------------------------------------------------------
module ddr2_port_arbiter #(
  parameter int MAX_WR_STREAK = 4,
  parameter int MAX_RD_STREAK = 4,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic              ctrl_clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_waitrequest,
  output logic              busy
);

  localparam int MAX_STREAK = (MAX_WR_STREAK > MAX_RD_STREAK) ? MAX_WR_STREAK : MAX_RD_STREAK;
  localparam int SW         = $clog2(MAX_STREAK + 1);

  localparam logic [SW-1:0]     WR_CAP    = SW'(MAX_WR_STREAK);
  localparam logic [SW-1:0]     RD_CAP    = SW'(MAX_RD_STREAK);
  localparam logic [SW-1:0]     ONE       = SW'(1);
  // ddr2_sys is word addressed on a byte address bus: low two bits are zero.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] wr_streak;
  logic [SW-1:0] rd_streak;
  logic          last_rd;     // previous grant went to the read client
  logic          contended;
  logic          pick_rd;

  assign contended = wr_req & rd_req;

  // Arbitration: write wins a tie by default; read wins once the write run
  // hits its cap, or while a read run is still under its own cap.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    pick_rd = 1'b0;
    if (rd_req && !wr_req) begin
      pick_rd = 1'b1;
    end else if (contended) begin
      pick_rd = (wr_streak >= WR_CAP) || (last_rd && (rd_streak < RD_CAP));
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the values from before the edge, whatever the order.
  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_streak <= '0;
      rd_streak <= '0;
      last_rd   <= 1'b0;
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_req || rd_req) begin
            busy <= 1'b1;
            if (pick_rd) begin
              state     <= ST_RD;
              mem_read  <= 1'b1;
              mem_addr  <= rd_addr & WORD_MASK;
              last_rd   <= 1'b1;
              wr_streak <= '0;
              // An uncontended grant starts a fresh run of one.
              rd_streak <= !contended ? ONE :
                           (rd_streak < RD_CAP) ? rd_streak + ONE : rd_streak;
            end else begin
              state     <= ST_WR;
              mem_write <= 1'b1;
              mem_addr  <= wr_addr & WORD_MASK;
              mem_wdata <= wr_data;
              last_rd   <= 1'b0;
              rd_streak <= '0;
              wr_streak <= !contended ? ONE :
                           (wr_streak < WR_CAP) ? wr_streak + ONE : wr_streak;
            end
          end
        end

        ST_WR: begin
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            wr_ack    <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_RD: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            rd_data  <= mem_rdata;
            rd_ack   <= 1'b1;
            state    <= ST_DONE;
          end
        end

        // Ack cycle: the client refreshes or drops its request here, so no
        // arbitration happens until the following IDLE edge.
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
